// File: rtl/mem_port_arbiter.sv
// Shares one SRAM controller between the IF and EXE pipeline stages.
// EXE has priority; a starvation counter forces IF through after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              exe_req,
    input  logic              exe_we,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              exe_ack,
    output logic [DATA_W-1:0] exe_rdata,
    output logic              mc_req,
    output logic              mc_we,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata,
    output logic              stall_if,
    output logic              stall_exe,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        owner_exe;
    logic [3:0]  starve_cnt;
    logic [7:0]  wd_cnt;
    logic        if_elig;
    logic        exe_elig;
    logic        turn;
    logic        starve_hit;
    logic        timeout_hit;
    logic        grant_if;
    logic        grant_exe;

    // Arbitration decode and next-state; an ack cycle is a turnaround cycle.
    always_comb begin
        state_nx    = state;
        if_elig     = if_req & ~if_ack;
        exe_elig    = exe_req & ~exe_ack;
        turn        = if_ack | exe_ack;
        starve_hit  = (starve_cnt == 4'(STARVE_MAX));
        timeout_hit = (wd_cnt == 8'(TIMEOUT));
        grant_if    = 1'b0;
        grant_exe   = 1'b0;
        unique case (state)
            IDLE: begin
                grant_if  = ~turn & if_elig & (~exe_elig | starve_hit);
                grant_exe = ~turn & exe_elig & ~grant_if;
                if (grant_if | grant_exe) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mc_done | timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latching, completion, watchdog and starvation tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_exe  <= 1'b0;
            mc_req     <= 1'b0;
            mc_we      <= 1'b0;
            mc_addr    <= '0;
            mc_wdata   <= '0;
            if_ack     <= 1'b0;
            exe_ack    <= 1'b0;
            if_rdata   <= '0;
            exe_rdata  <= '0;
            err        <= 1'b0;
            starve_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            if_ack  <= 1'b0;
            exe_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_if | grant_exe) begin
                        owner_exe <= grant_exe;
                        mc_req    <= 1'b1;
                        mc_we     <= grant_exe & exe_we;
                        mc_addr   <= grant_exe ? exe_addr : if_addr;
                        mc_wdata  <= grant_exe ? exe_wdata : '0;
                        wd_cnt    <= '0;
                        if (grant_if || !if_req) begin
                            starve_cnt <= '0;
                        end else if (if_elig && starve_cnt != 4'hF) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                BUSY: begin
                    if (mc_done) begin
                        mc_req <= 1'b0;
                        if (owner_exe) begin
                            exe_ack <= 1'b1;
                            if (!mc_we) exe_rdata <= mc_rdata;
                        end else begin
                            if_ack <= 1'b1;
                            if (!mc_we) if_rdata <= mc_rdata;
                        end
                    end else if (timeout_hit) begin
                        mc_req <= 1'b0;
                        err    <= 1'b1;
                        if (owner_exe) begin
                            exe_ack   <= 1'b1;
                            exe_rdata <= '1;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= '1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_exe = exe_req & ~exe_ack;
    assign busy      = (state == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Drives on negedge, samples on negedge after each posedge.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        exe_req;
    logic        exe_we;
    logic [15:0] exe_addr;
    logic [15:0] exe_wdata;
    logic        exe_ack;
    logic [15:0] exe_rdata;
    logic        mc_req;
    logic        mc_we;
    logic [15:0] mc_addr;
    logic [15:0] mc_wdata;
    logic        mc_done;
    logic [15:0] mc_rdata;
    logic        stall_if;
    logic        stall_exe;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .STARVE_MAX(3),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .exe_req(exe_req),
        .exe_we(exe_we),
        .exe_addr(exe_addr),
        .exe_wdata(exe_wdata),
        .exe_ack(exe_ack),
        .exe_rdata(exe_rdata),
        .mc_req(mc_req),
        .mc_we(mc_we),
        .mc_addr(mc_addr),
        .mc_wdata(mc_wdata),
        .mc_done(mc_done),
        .mc_rdata(mc_rdata),
        .stall_if(stall_if),
        .stall_exe(stall_exe),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mc_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_granted"}, 32'(ok), 32'd1);
    endtask

    task automatic finish_txn(input logic [15:0] rd);
        mc_done  = 1'b1;
        mc_rdata = rd;
        @(negedge clk);
        mc_done  = 1'b0;
        mc_rdata = 16'h0;
    endtask

    initial begin
        int cnt;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 16'h0;
        exe_req   = 1'b0;
        exe_we    = 1'b0;
        exe_addr  = 16'h0;
        exe_wdata = 16'h0;
        mc_done   = 1'b0;
        mc_rdata  = 16'h0;
        #1;
        chk("rst_mc_req", 32'(mc_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_mc_addr", 32'(mc_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // single IF read, done 3 cycles after mc_req
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 16'h0100;
        wait_req("t1");
        chk("t1_addr", 32'(mc_addr), 32'h0100);
        chk("t1_we", 32'(mc_we), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_stall", 32'(stall_if), 32'd1);
        repeat (2) @(negedge clk);
        finish_txn(16'h1234);
        chk("t1_ack", 32'(if_ack), 32'd1);
        chk("t1_rdata", 32'(if_rdata), 32'h1234);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_stall_ack", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_ack_pulse", 32'(if_ack), 32'd0);

        // simultaneous arrival: EXE first, then IF
        exe_req  = 1'b1;
        exe_we   = 1'b0;
        exe_addr = 16'h8000;
        if_req   = 1'b1;
        if_addr  = 16'h0200;
        wait_req("t2e");
        chk("t2_exe_first", 32'(mc_addr), 32'h8000);
        finish_txn(16'hAAAA);
        chk("t2_exe_ack", 32'(exe_ack), 32'd1);
        chk("t2_exe_rdata", 32'(exe_rdata), 32'hAAAA);
        chk("t2_if_ack_low", 32'(if_ack), 32'd0);
        exe_req = 1'b0;
        wait_req("t2i");
        chk("t2_if_next", 32'(mc_addr), 32'h0200);
        finish_txn(16'h5555);
        chk("t2_if_ack", 32'(if_ack), 32'd1);
        chk("t2_if_rdata", 32'(if_rdata), 32'h5555);
        if_req = 1'b0;

        // mc_done while idle is ignored
        @(negedge clk);
        mc_done = 1'b1;
        @(negedge clk);
        mc_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_acks", 32'({if_ack, exe_ack}), 32'd0);

        // starvation: IF forced after 3 EXE grants
        if_req   = 1'b1;
        if_addr  = 16'h0300;
        exe_req  = 1'b1;
        exe_addr = 16'hA001;
        for (int k = 0; k < 3; k++) begin
            wait_req("t3e");
            chk("t3_exe_addr", 32'(mc_addr), 32'hA001 + 32'(k));
            finish_txn(16'hC000 + 16'(k));
            chk("t3_exe_ack", 32'(exe_ack), 32'd1);
            exe_addr = 16'hA002 + 16'(k);
        end
        wait_req("t3i");
        chk("t3_if_forced", 32'(mc_addr), 32'h0300);
        finish_txn(16'h3333);
        chk("t3_if_ack", 32'(if_ack), 32'd1);
        chk("t3_exe_rdata", 32'(exe_rdata), 32'hC002);
        if_req  = 1'b0;
        exe_req = 1'b0;

        // EXE write leaves exe_rdata unchanged
        @(negedge clk);
        exe_req   = 1'b1;
        exe_we    = 1'b1;
        exe_addr  = 16'h0010;
        exe_wdata = 16'hBEEF;
        wait_req("t4");
        chk("t4_we", 32'(mc_we), 32'd1);
        chk("t4_wdata", 32'(mc_wdata), 32'hBEEF);
        chk("t4_addr", 32'(mc_addr), 32'h0010);
        finish_txn(16'h7777);
        chk("t4_ack", 32'(exe_ack), 32'd1);
        chk("t4_rdata_kept", 32'(exe_rdata), 32'hC002);
        exe_req = 1'b0;
        exe_we  = 1'b0;

        // watchdog timeout: wd_cnt 0..TO while BUSY, abort at TO
        if_req  = 1'b1;
        if_addr = 16'h0400;
        wait_req("t5");
        cnt = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!mc_req) break;
            cnt++;
        end
        chk("t5_req_cycles", 32'(cnt), 32'(TO + 1));
        chk("t5_ack", 32'(if_ack), 32'd1);
        chk("t5_rdata", 32'(if_rdata), 32'hFFFF);
        chk("t5_err", 32'(err), 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        exe_req  = 1'b1;
        exe_addr = 16'h0020;
        wait_req("t5b");
        finish_txn(16'h1111);
        chk("t5_exe_rdata", 32'(exe_rdata), 32'h1111);
        chk("t5_err_sticky", 32'(err), 32'd1);
        exe_req = 1'b0;

        // reset during BUSY, pending request re-granted
        @(negedge clk);
        exe_req  = 1'b1;
        exe_addr = 16'h4000;
        wait_req("t6");
        #2 rst = 1'b0;
        #1;
        chk("t6_req_async", 32'(mc_req), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err_clr", 32'(err), 32'd0);
        chk("t6_no_ack", 32'(exe_ack), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_req("t6r");
        chk("t6_regrant", 32'(mc_addr), 32'h4000);
        finish_txn(16'h2222);
        chk("t6_ack", 32'(exe_ack), 32'd1);
        chk("t6_rdata", 32'(exe_rdata), 32'h2222);
        exe_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
